serial_adder_ctrl: RTL
======================

# serial_adder_ctrl

Bit-serial adder controller that drives a single instance of the existing one-bit `full_adder` cell. It adds two WIDTH-bit operands LSB-first, one bit per clock, and holds the bit-to-bit carry in a flip-flop. A start/busy/done handshake sequences the operation. It is the area-minimal adder option for datapaths that can tolerate WIDTH-cycle latency.

## Interface
- WIDTH, 8, operand and result width in bits; legal range 2..32.

- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request pulse; sampled only in IDLE.
- a  input  WIDTH  operand A; sampled on the accepting edge only.
- b  input  WIDTH  operand B; sampled on the accepting edge only.
- c_in  input  1  carry-in; sampled on the accepting edge only.
- busy  output  1  high while the add is in progress (state ADD).
- done  output  1  one-cycle completion pulse (state DONE).
- sum  output  WIDTH  registered result; held until the next completion.
- c_out  output  1  registered carry-out; held with sum.

## Operation
- Exactly one `full_adder` instance, connected positionally as (a_bit, b_bit, carry, s_bit, co_bit).
  - a_bit and b_bit are the LSBs of the internal operand shift registers.
  - carry is the internal carry flip-flop.
- Internal state:
  - shift registers sa and sb (WIDTH bits each);
  - result shift register sr (WIDTH bits);
  - carry flip-flop cy;
  - bit counter cnt, wide enough to hold 0..WIDTH-1;
  - 2-bit FSM.
- FSM states and transitions:
  - IDLE: start=1 causes sa<=a, sb<=b, cy<=c_in, cnt<=0, sr<=0, and the move to ADD. start=0 keeps IDLE.
  - ADD: every edge performs the following, then cnt<=cnt+1:
    - sa and sb shift right by one;
    - sr shifts right with s_bit entering at the MSB;
    - cy<=co_bit.
  - ADD exit: on the edge where cnt==WIDTH-1, the final shift is done, sum<={s_bit, sr[WIDTH-1:1]}, c_out<=co_bit, and the FSM moves to DONE.
  - DONE: unconditionally returns to IDLE on the next edge.
- Arithmetic: {c_out, sum} = a + b + c_in, exact and unsigned, over WIDTH+1 bits. No overflow flag.
- start is ignored in ADD and DONE. It is not queued.
- a, b and c_in may change freely after the accepting edge without affecting the result.
- sum and c_out change only on the ADD-to-DONE edge. They are stable at every other time, including during the next ADD.
- Reset asserted at any time, including mid-ADD:
  - state becomes IDLE immediately;
  - busy=0, done=0, sum=0, c_out=0;
  - sa, sb, sr, cy and cnt clear to 0;
  - the partial result is discarded.
- Release of reset takes effect on clock edges only. start high on the first edge after release is accepted.

## Timing
- Reset values: busy=0, done=0, sum=0, c_out=0; state IDLE.
- The accepting edge is edge 0, where start=1 is sampled in IDLE.
- busy is high from after edge 0 until edge WIDTH, i.e. exactly WIDTH cycles.
- done is high from after edge WIDTH until edge WIDTH+1, i.e. exactly one cycle.
- sum and c_out are valid from edge WIDTH onward.
- Earliest back-to-back operation: a new start is accepted at edge WIDTH+1. Throughput is one add per WIDTH+1 cycles.
- busy and done are never high together. done is never high for two consecutive cycles.
- The combinational path through full_adder is registered-to-registered only. No input-to-output combinational path exists.

## Test plan
- Reset, then a=8'h00, b=8'h00, c_in=1 with start for one cycle (WIDTH=8).
  - Required: busy high for 8 cycles.
  - Required: done pulses at edge 8 with sum=8'h01, c_out=0.
- a=8'hFF, b=8'h01, c_in=0.
  - Required: sum=8'h00, c_out=1.
  - Required: sum and c_out stay unchanged through the following idle cycles.
- a=8'hA5, b=8'h5A, c_in=1.
  - Required: sum=8'h00, c_out=1.
  - Then a=8'h3C, b=8'h42, c_in=0 with start held high throughout: the first result is as above; the second start is accepted at edge 9; sum=8'h7E, c_out=0 at edge 17.
- Start accepted with a=8'h10, b=8'h20. Toggle a, b and c_in randomly and pulse start again during ADD.
  - Required: the second pulse is ignored.
  - Required: the result is sum=8'h30, c_out=0, and done is a single pulse.
- Start accepted with a=8'hFF, b=8'hFF, c_in=1. Assert rst asynchronously between clock edges at cycle 4.
  - Required: busy, done, sum and c_out go to 0 before the next edge.
  - Required: after release, a new add of 8'h01+8'h01 gives sum=8'h02.
- Exhaustive sweep at WIDTH=4: all a, b and c_in combinations.
  - Required: {c_out, sum} == a+b+c_in on every done pulse.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one full_adder cell, LSB-first over WIDTH clocks, carry held in a flop.
// start/busy/done handshake; sum/c_out registered and held until the next completion.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);
endmodule

// state | meaning
// IDLE  | waiting for start; operands loaded on the accepting edge
// ADD   | one bit per edge through the full_adder, cnt counts 0..WIDTH-1
// DONE  | one-cycle completion pulse, then back to IDLE
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic             cy_q, cy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_out_q, c_out_d;

  logic s_bit;
  logic co_bit;

  // The adder only ever sees flop outputs, so there is no input-to-output path.
  full_adder u_fa (sa_q[0], sb_q[0], cy_q, s_bit, co_bit);

  // sr_q[0] is shifted out on every ADD edge and never needed again.
  logic sr_lsb_unused;
  assign sr_lsb_unused = sr_q[0];

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    sr_d    = sr_q;
    cy_d    = cy_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    c_out_d = c_out_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          cy_d    = c_in;
          cnt_d   = '0;
          sr_d    = '0;
          state_d = S_ADD;
        end
      end

      S_ADD: begin
        sa_d  = {1'b0, sa_q[WIDTH-1:1]};
        sb_d  = {1'b0, sb_q[WIDTH-1:1]};
        sr_d  = {s_bit, sr_q[WIDTH-1:1]};
        cy_d  = co_bit;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          sum_d   = {s_bit, sr_q[WIDTH-1:1]};
          c_out_d = co_bit;
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      sr_q    <= '0;
      cy_q    <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      sr_q    <= sr_d;
      cy_q    <= cy_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      c_out_q <= c_out_d;
    end
  end

  assign busy  = (state_q == S_ADD);
  assign done  = (state_q == S_DONE);
  assign sum   = sum_q;
  assign c_out = c_out_q;

endmodule
